// File: rtl/wakeup_queue_if.sv
// Signal bundle between Dispatch, the wakeup queue and the FU issue ports.
// master = Dispatch/FU side, slave = queue side.
interface wakeup_queue_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_FUS     = 4,
  parameter int NUM_COLS    = 4,
  parameter int LAT_WIDTH   = 2
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int LOC_W = $clog2(NUM_FUS) + $clog2(NUM_COLS);

  logic                   flush;
  logic                   entry_free;
  logic [IDX_W-1:0]       entry_index;
  logic                   dispatch_valid;
  logic [LAT_WIDTH-1:0]   latency;
  logic                   src1_dp_en;
  logic                   src2_dp_en;
  logic [LOC_W-1:0]       src1_dp_loc;
  logic [LOC_W-1:0]       src2_dp_loc;
  logic [LOC_W-1:0]       dst_loc;
  logic                   issue_valid;
  logic [IDX_W-1:0]       issue_index;
  logic [LOC_W-1:0]       issue_dst_loc;
  logic                   issue_ready;
  logic [NUM_ENTRIES-1:0] wakeup_mask;

  modport master (
    output flush, dispatch_valid, latency, src1_dp_en, src2_dp_en,
           src1_dp_loc, src2_dp_loc, dst_loc, issue_ready,
    input  entry_free, entry_index, issue_valid, issue_index,
           issue_dst_loc, wakeup_mask
  );

  modport slave (
    input  flush, dispatch_valid, latency, src1_dp_en, src2_dp_en,
           src1_dp_loc, src2_dp_loc, dst_loc, issue_ready,
    output entry_free, entry_index, issue_valid, issue_index,
           issue_dst_loc, wakeup_mask
  );
endinterface

// File: rtl/wakeup_queue.sv
// Wakeup queue: holds dispatched instructions, tracks producer dependencies,
// issues the lowest ready slot and broadcasts its destination after its latency.
module wakeup_queue #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_FUS     = 4,
  parameter int NUM_COLS    = 4,
  parameter int LAT_WIDTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  wakeup_queue_if.slave bus
);
  localparam int FU_IDX_WIDTH  = $clog2(NUM_FUS);
  localparam int COL_IDX_WIDTH = $clog2(NUM_COLS);
  localparam int IDX_W         = $clog2(NUM_ENTRIES);
  localparam int LOC_W         = FU_IDX_WIDTH + COL_IDX_WIDTH;

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EXEC  = 2'd3;

  logic [NUM_ENTRIES-1:0]            free_vec;
  logic [NUM_ENTRIES-1:0]            ready_vec;
  logic [NUM_ENTRIES-1:0]            bcast_vec;
  logic [NUM_ENTRIES-1:0][LOC_W-1:0] dst_all;
  logic [IDX_W-1:0]                  free_idx;
  logic [IDX_W-1:0]                  ready_idx;
  logic                              any_free;
  logic                              any_ready;
  logic                              disp_fire;
  logic                              issue_fire;
  logic                              disp_hit1;
  logic                              disp_hit2;
  logic [LAT_WIDTH-1:0]              disp_lat;

  always_comb begin
    free_idx  = '0;
    ready_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i])  free_idx  = IDX_W'(i);
      if (ready_vec[i]) ready_idx = IDX_W'(i);
    end
  end

  assign any_free   = |free_vec;
  assign any_ready  = |ready_vec;
  assign disp_fire  = bus.dispatch_valid && any_free;
  assign issue_fire = any_ready && bus.issue_ready;
  assign disp_lat   = (bus.latency == '0) ? LAT_WIDTH'(1) : bus.latency;

  // Same-cycle bypass: a source produced by a slot broadcasting right now
  // is stored as already satisfied.
  always_comb begin
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      if (bcast_vec[j] && (dst_all[j] == bus.src1_dp_loc)) disp_hit1 = 1'b1;
      if (bcast_vec[j] && (dst_all[j] == bus.src2_dp_loc)) disp_hit2 = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot
    logic [1:0]           state_q, state_d;
    logic                 wait1_q, wait1_d;
    logic                 wait2_q, wait2_d;
    logic [LOC_W-1:0]     loc1_q, loc1_d;
    logic [LOC_W-1:0]     loc2_q, loc2_d;
    logic [LOC_W-1:0]     dst_q, dst_d;
    logic [LAT_WIDTH-1:0] lat_q, lat_d;
    logic [LAT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 hit1;
    logic                 hit2;

    assign free_vec[gi]  = (state_q == ST_FREE);
    assign ready_vec[gi] = (state_q == ST_READY);
    assign bcast_vec[gi] = (state_q == ST_EXEC) && (cnt_q == LAT_WIDTH'(1)) && !bus.flush;
    assign dst_all[gi]   = dst_q;

    always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (bcast_vec[j] && (dst_all[j] == loc1_q)) hit1 = 1'b1;
        if (bcast_vec[j] && (dst_all[j] == loc2_q)) hit2 = 1'b1;
      end
    end

    always_comb begin
      state_d = state_q;
      wait1_d = wait1_q;
      wait2_d = wait2_q;
      loc1_d  = loc1_q;
      loc2_d  = loc2_q;
      dst_d   = dst_q;
      lat_d   = lat_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_FREE: begin
          if (disp_fire && (free_idx == IDX_W'(gi))) begin
            wait1_d = bus.src1_dp_en && !disp_hit1;
            wait2_d = bus.src2_dp_en && !disp_hit2;
            loc1_d  = bus.src1_dp_loc;
            loc2_d  = bus.src2_dp_loc;
            dst_d   = bus.dst_loc;
            lat_d   = disp_lat;
            state_d = (wait1_d || wait2_d) ? ST_WAIT : ST_READY;
          end
        end
        ST_WAIT: begin
          if (hit1) wait1_d = 1'b0;
          if (hit2) wait2_d = 1'b0;
          if (!wait1_d && !wait2_d) state_d = ST_READY;
        end
        ST_READY: begin
          if (issue_fire && (ready_idx == IDX_W'(gi))) begin
            state_d = ST_EXEC;
            cnt_d   = lat_q;
          end
        end
        default: begin
          // The broadcast cycle is count==1; the slot frees on the next edge.
          if (cnt_q <= LAT_WIDTH'(1)) begin
            state_d = ST_FREE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LAT_WIDTH'(1);
          end
        end
      endcase
      if (bus.flush) state_d = ST_FREE;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_FREE;
        wait1_q <= 1'b0;
        wait2_q <= 1'b0;
        loc1_q  <= '0;
        loc2_q  <= '0;
        dst_q   <= '0;
        lat_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        wait1_q <= wait1_d;
        wait2_q <= wait2_d;
        loc1_q  <= loc1_d;
        loc2_q  <= loc2_d;
        dst_q   <= dst_d;
        lat_q   <= lat_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  assign bus.entry_free    = any_free;
  assign bus.entry_index   = free_idx;
  assign bus.issue_valid   = any_ready;
  assign bus.issue_index   = ready_idx;
  assign bus.issue_dst_loc = any_ready ? dst_all[ready_idx] : '0;
  assign bus.wakeup_mask   = bcast_vec;
endmodule

// File: doc/wakeup_queue.md
Name: wakeup_queue

Overview:
- Wakeup-side receiver of the Dispatch↔Wakeup protocol.
- Holds dispatched instructions in NUM_ENTRIES slots, advertises a free slot to Dispatch and tracks per-source dependencies on producer locations ({fu_idx, col_idx}).
- Selects one ready entry per cycle for issue, runs a latency countdown after issue, and broadcasts the entry's destination location to wake dependents.
- Sits between Dispatch and the FU issue ports.

Parameters:
- NUM_ENTRIES, 8, number of queue slots (power of 2, ≥2).
- NUM_FUS, 4, functional units; FU_IDX_WIDTH = $clog2(NUM_FUS).
- NUM_COLS, 4, columns per FU; COL_IDX_WIDTH = $clog2(NUM_COLS).
- LAT_WIDTH, 2, width of the latency field.
- Derived: IDX_W = $clog2(NUM_ENTRIES); LOC_W = FU_IDX_WIDTH + COL_IDX_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries
- entry_free  out  1  at least one slot is FREE
- entry_index  out  IDX_W  lowest-index FREE slot
- dispatch_valid  in  1  write dispatch fields into slot entry_index
- latency  in  LAT_WIDTH  cycles from issue to broadcast
- src1_dp_en  in  1  src1 waits on a producer
- src2_dp_en  in  1  src2 waits on a producer
- src1_dp_loc  in  LOC_W  src1 producer location
- src2_dp_loc  in  LOC_W  src2 producer location
- dst_loc  in  LOC_W  this instruction's own location
- issue_valid  out  1  a READY entry is offered
- issue_index  out  IDX_W  offered slot
- issue_dst_loc  out  LOC_W  dst_loc of offered slot
- issue_ready  in  1  FU accepts the offer
- wakeup_mask  out  NUM_ENTRIES  slots broadcasting this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all slots FREE. entry_free=1, entry_index=0, issue_valid=0, issue_index=0, issue_dst_loc=0, wakeup_mask=0.
- Per-slot states: FREE, WAIT, READY, EXEC(count).
- FREE→WAIT/READY on dispatch_valid && entry_free into slot entry_index.
  - Store wait1 = src1_dp_en, wait2 = src2_dp_en, both locs, dst_loc, and latency (0 is treated as 1).
  - Bypass: a src whose loc matches any slot broadcasting in the same cycle is stored with wait cleared.
  - Slot enters READY when both waits are clear, otherwise WAIT.
- dispatch_valid with entry_free=0 is ignored; the bench flags it as a protocol error.
- Broadcast clearing: any waiting src whose loc equals the dst_loc of a broadcasting slot clears. Multiple broadcasts in one cycle are all honoured. The clear is registered, so WAIT→READY is visible the next cycle.
- Issue select is combinational:
  - issue_valid = any READY; issue_index = lowest READY index.
  - On issue_valid && issue_ready, that slot goes READY→EXEC with count = latency. One issue per cycle.
- EXEC: count decrements each cycle. The cycle count==1, the slot's wakeup_mask bit is 1 (combinational from state). Next edge the slot becomes FREE.
- Timing: issue at edge t, broadcast during cycle t+L, dependent READY at t+L+1, dependent issue earliest t+L+1. The freed slot is allocatable at t+L+1.
- entry_free and entry_index are combinational from registered state only; no same-cycle reuse of a slot that is freeing.
- Simultaneous dispatch, issue and broadcast on different slots: all take effect.
- Flush: all slots FREE next edge. Priority over dispatch and issue. wakeup_mask is forced to 0 during the flush cycle.
- Reset mid-operation: identical to the reset values above; in-flight counts are discarded.

Test Plan:
- Reset, then dispatch A (no deps, dst_loc=5, lat=2) → entry_index=0 and A in slot 0. Cycle+1: issue_valid=1, issue_index=0. Issue accepted at t → wakeup_mask=8'h01 during t+2, and entry_free again shows index 0 at t+3.
- Dispatch B with src1_dp_en=1, src1_dp_loc=5 behind A (lat=1) → B stays WAIT. A issues at t, broadcasts at t+1, B issue_valid at t+2.
- Fill all 8 slots with waiting entries → entry_free=0. A further dispatch_valid has no state change. Clearing the loc of slot 3's producer makes issue_index=3.
- A (lat=3) issued at t, C (lat=1) issued at t+2 → wakeup_mask has both bits set at t+3. A dependent waiting on both locs is READY at t+4.
- Dispatch with src2_dp_loc equal to the loc broadcasting that same cycle → stored READY, issue_valid next cycle.
- Flush with 4 slots in WAIT/EXEC and dispatch_valid=1 → next cycle all FREE, entry_index=0, wakeup_mask=0, issue_valid=0.
